bcd_display_ctrl: RTL and testbench
===================================

# bcd_display_ctrl

Write-side controller for the 8-digit BCD display register file feeding the 7-segment multiplexing driver. Two independent requesters (A and B) write single digits through valid/ready handshakes, with fair round-robin arbitration. A clear strobe runs an 8-cycle sequenced wipe of all digits. The eight 4-bit outputs connect directly to the driver's BCD1..BCD8 inputs.

## Interface
- No parameters; digit count (8) and digit width (4) are package constants.
- clk  in  1  single system clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- a_valid  in  1  requester A has a write pending.
- a_addr  in  3  A target digit, 0 maps to BCD1 and 7 maps to BCD8.
- a_data  in  4  A digit value, stored verbatim (10..15 permitted).
- a_ready  out  1  A write accepted this cycle when a_valid && a_ready.
- b_valid, b_addr, b_data, b_ready: same as A for requester B.
- clr  in  1  start-clear strobe, level-sampled.
- hold  in  1  freeze: blocks all writes and new clears.
- busy  out  1  high while the clear sequence runs.
- BCD1..BCD8  out  4 each  registered digit values.

## Operation
- States are IDLE and CLEAR. The state register, the 3-bit clear pointer `cptr`, and the last-grant flag `lg` are registered.
- IDLE, in priority order:
  - rst low: both readies are 0.
  - hold high: both readies are 0. clr is ignored.
  - clr high: both readies are 0. Next state is CLEAR with cptr=0.
  - Otherwise arbitrate:
    - Only one valid: that requester gets ready=1.
    - Both valid: the requester other than `lg` gets ready=1.
    - Neither valid: both readies are 0.
- Ready is combinational from state, hold, clr, both valids and `lg`. Ready never depends on addr or data.
- Accepted write: digit[addr] <= data at the edge. `lg` updates to the accepted requester. At most one write per cycle.
- CLEAR:
  - Both readies are 0 and busy=1. hold and clr are ignored.
  - Each cycle: digit[cptr] <= 0 and cptr <= cptr+1.
  - When cptr==7, that digit is zeroed and the next state is IDLE.
- Valid-side rule: a requester holds valid/addr/data stable until accepted. The block does not check this.

## Timing
- Reset values: all BCDx=0, state=IDLE, cptr=0, lg=B (so A wins the first contention), busy=0.
- Readies are 0 in any cycle with rst low.
- Write latency: a write accepted at the edge closing cycle N is visible on BCDx in cycle N+1.
- Clear:
  - clr high in IDLE during cycle N (not held).
  - busy=1 in cycles N+1..N+8.
  - BCD(k+1)=0 visible from cycle N+2+k; all zero by N+9.
  - Readies are low N..N+8. IDLE resumes at N+9.
- clr held high across the end of a clear starts a new clear at N+9. No write is granted in between.
- Simultaneous clr and valid in IDLE: clear wins; the write stays pending.
- Writes are never merged into a running clear.
- rst low mid-CLEAR: next edge goes to IDLE with all digits 0 and cptr=0.
- Same requester kept valid with no contender: accepted every cycle (back-to-back, 1 write/cycle).

## Structure
- Package `display_pkg` holds:
  - NDIGITS=8 and BCD_W=4.
  - The state typedef (IDLE, CLEAR).
  - The requester-ID typedef (REQ_A, REQ_B).
- Sub-module `rr_arb2`: 2-input round-robin grant logic.
  - Inputs: two requests, `lg`, and an enable.
  - Outputs: a one-hot grant.
  - Purely combinational. `lg` stays in the parent.
- Digit storage is eight 4-bit registers with explicit per-index write enables, not an inferred RAM.

## Test plan
- Reset: drive rst=0 for 2 cycles with a_valid=1 -> a_ready=0, all BCDx=0, busy=0; release, next cycle a_ready=1.
- Single write: A writes addr=2, data=7 -> BCD3=7 one cycle after acceptance; other digits unchanged.
- Contention: A and B both valid (A addr 0 data 1, then addr 1 data 2; B addr 0 data 9) -> A, B, A order. Final BCD1=9 (B second), BCD2=2; never two grants in one cycle.
- Clear: load all digits with 5, pulse clr in cycle N with b_valid=1 -> busy=1 for N+1..N+8, BCD1 zero at N+2, BCD8 zero at N+9. b_ready stays low until N+9, B's write lands at N+10.
- Hold/clr interaction: hold=1 with clr=1 and a_valid=1 -> no clear starts, no write, busy=0; drop hold -> clear starts.
- Reset mid-clear: rst=0 at cycle N+4 of a clear -> all BCDx=0, busy=0, IDLE next cycle; a fresh write is accepted after release.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and types for the BCD display write controller.
package display_pkg;

  localparam int NDIGITS = 8;
  localparam int BCD_W   = 4;
  localparam int ADDR_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant logic; the last-grant flag is owned by the caller.
module rr_arb2
  import display_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  req_id_e    lg,
  input  logic       en,
  output logic [1:0] grant
);

  // One-hot grant: bit 0 is A, bit 1 is B; on contention the requester that did not win last goes
  always_comb begin
    grant = 2'b00;
    if (!en) begin
      grant = 2'b00;
    end else if (req_a && req_b) begin
      grant = (lg == REQ_B) ? 2'b01 : 2'b10;
    end else if (req_a) begin
      grant = 2'b01;
    end else if (req_b) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Write-side controller for the 8-digit BCD display register file: two
// round-robin arbitrated writers plus a sequenced one-digit-per-cycle clear.
module bcd_display_ctrl
  import display_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [BCD_W-1:0]  a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [BCD_W-1:0]  b_data,
  output logic              b_ready,
  input  logic              clr,
  input  logic              hold,
  output logic              busy,
  output logic [BCD_W-1:0]  BCD1,
  output logic [BCD_W-1:0]  BCD2,
  output logic [BCD_W-1:0]  BCD3,
  output logic [BCD_W-1:0]  BCD4,
  output logic [BCD_W-1:0]  BCD5,
  output logic [BCD_W-1:0]  BCD6,
  output logic [BCD_W-1:0]  BCD7,
  output logic [BCD_W-1:0]  BCD8
);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [ADDR_W-1:0]  cptr_r;
  logic [ADDR_W-1:0]  cptr_nxt_s;
  req_id_e            lg_r;
  req_id_e            lg_nxt_s;
  logic               arb_en_s;
  logic [1:0]         grant_s;
  logic [NDIGITS-1:0] we_s;
  logic [BCD_W-1:0]   wdata_s [NDIGITS];
  logic [BCD_W-1:0]   digit_r [NDIGITS];

  // Arbitration only runs in an idle, unfrozen cycle with no clear request
  always_comb begin
    arb_en_s = 1'b0;
    if (rst && (state_r == IDLE) && !hold && !clr) begin
      arb_en_s = 1'b1;
    end else begin
      arb_en_s = 1'b0;
    end
  end

  rr_arb2 u_arb (
    .req_a (a_valid),
    .req_b (b_valid),
    .lg    (lg_r),
    .en    (arb_en_s),
    .grant (grant_s)
  );

  assign a_ready = grant_s[0];
  assign b_ready = grant_s[1];
  assign busy    = (state_r == CLEAR);

  // Next-state, clear pointer and last-grant selection
  always_comb begin
    state_nxt_s = state_r;
    cptr_nxt_s  = cptr_r;
    lg_nxt_s    = lg_r;
    case (state_r)
      IDLE: begin
        if (!hold && clr) begin
          state_nxt_s = CLEAR;
          cptr_nxt_s  = {ADDR_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
          cptr_nxt_s  = cptr_r;
        end
      end
      CLEAR: begin
        cptr_nxt_s = cptr_r + 3'd1;
        if (cptr_r == 3'd7) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cptr_nxt_s  = {ADDR_W{1'b0}};
      end
    endcase
    if (grant_s[0]) begin
      lg_nxt_s = REQ_A;
    end else if (grant_s[1]) begin
      lg_nxt_s = REQ_B;
    end else begin
      lg_nxt_s = lg_r;
    end
  end

  // Per-digit write enables: the granted requester in IDLE, the clear pointer in CLEAR
  always_comb begin
    for (int i = 0; i < NDIGITS; i++) begin
      we_s[i]    = 1'b0;
      wdata_s[i] = {BCD_W{1'b0}};
    end
    if (state_r == CLEAR) begin
      we_s[cptr_r]    = 1'b1;
      wdata_s[cptr_r] = {BCD_W{1'b0}};
    end else if (grant_s[0]) begin
      we_s[a_addr]    = 1'b1;
      wdata_s[a_addr] = a_data;
    end else if (grant_s[1]) begin
      we_s[b_addr]    = 1'b1;
      wdata_s[b_addr] = b_data;
    end else begin
      we_s = {NDIGITS{1'b0}};
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cptr_r  <= {ADDR_W{1'b0}};
      lg_r    <= REQ_B;
    end else begin
      state_r <= state_nxt_s;
      cptr_r  <= cptr_nxt_s;
      lg_r    <= lg_nxt_s;
    end
  end

  // Digit register file, one explicit enable per digit
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NDIGITS; i++) begin
        digit_r[i] <= {BCD_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NDIGITS; i++) begin
        if (we_s[i]) begin
          digit_r[i] <= wdata_s[i];
        end
      end
    end
  end

  assign BCD1 = digit_r[0];
  assign BCD2 = digit_r[1];
  assign BCD3 = digit_r[2];
  assign BCD4 = digit_r[3];
  assign BCD5 = digit_r[4];
  assign BCD6 = digit_r[5];
  assign BCD7 = digit_r[6];
  assign BCD8 = digit_r[7];

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed self-checking bench for bcd_display_ctrl.
module tb_bcd_display_ctrl;

  logic       clk;
  logic       rst;
  logic       a_valid, b_valid;
  logic [2:0] a_addr, b_addr;
  logic [3:0] a_data, b_data;
  logic       a_ready, b_ready;
  logic       clr, hold, busy;
  logic [3:0] bcd1, bcd2, bcd3, bcd4, bcd5, bcd6, bcd7, bcd8;
  logic [3:0] dig [8];

  int checks;
  int failures;

  bcd_display_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .b_ready (b_ready),
    .clr     (clr),
    .hold    (hold),
    .busy    (busy),
    .BCD1    (bcd1),
    .BCD2    (bcd2),
    .BCD3    (bcd3),
    .BCD4    (bcd4),
    .BCD5    (bcd5),
    .BCD6    (bcd6),
    .BCD7    (bcd7),
    .BCD8    (bcd8)
  );

  always_comb begin
    dig[0] = bcd1; dig[1] = bcd2; dig[2] = bcd3; dig[3] = bcd4;
    dig[4] = bcd5; dig[5] = bcd6; dig[6] = bcd7; dig[7] = bcd8;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change here, checks follow a #1 later
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = 3'd0; a_data = 4'd0;
    b_valid = 1'b0; b_addr = 3'd0; b_data = 4'd0;
    clr = 1'b0; hold = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    a_valid = 1'b1; a_addr = 3'd0; a_data = 4'd3;
    tick();
    tick();
    #1;
    checks++;
    if (a_ready !== 1'b0) begin failures++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dig[i] !== 4'd0) begin failures++; $display("FAIL reset_bcd%0d got=%0d exp=0", i + 1, dig[i]); end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin failures++; $display("FAIL release_a_ready got=%b exp=1", a_ready); end
    tick();
    a_valid = 1'b0;
    #1;
    checks++;
    if (bcd1 !== 4'd3) begin failures++; $display("FAIL release_write got=%0d exp=3", bcd1); end
  endtask

  task automatic test_single_write();
    do_reset();
    a_valid = 1'b1; a_addr = 3'd2; a_data = 4'd7;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", a_ready); end
    tick();
    a_valid = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dig[i] !== ((i == 2) ? 4'd7 : 4'd0)) begin
        failures++; $display("FAIL single_bcd%0d got=%0d exp=%0d", i + 1, dig[i], (i == 2) ? 7 : 0);
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    a_valid = 1'b1; a_addr = 3'd0; a_data = 4'd1;
    b_valid = 1'b1; b_addr = 3'd0; b_data = 4'd9;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin failures++; $display("FAIL cont_grant1 got=%b exp=10", {a_ready, b_ready}); end
    tick();
    a_addr = 3'd1; a_data = 4'd2;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin failures++; $display("FAIL cont_grant2 got=%b exp=01", {a_ready, b_ready}); end
    checks++;
    if (bcd1 !== 4'd1) begin failures++; $display("FAIL cont_bcd1_a got=%0d exp=1", bcd1); end
    tick();
    b_valid = 1'b0;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin failures++; $display("FAIL cont_grant3 got=%b exp=10", {a_ready, b_ready}); end
    checks++;
    if (bcd1 !== 4'd9) begin failures++; $display("FAIL cont_bcd1_b got=%0d exp=9", bcd1); end
    tick();
    a_valid = 1'b0;
    #1;
    checks++;
    if (bcd1 !== 4'd9 || bcd2 !== 4'd2) begin
      failures++; $display("FAIL cont_final got=%0d,%0d exp=9,2", bcd1, bcd2);
    end
  endtask

  task automatic test_back_to_back_and_clear();
    logic [3:0] exp_v;
    do_reset();
    a_valid = 1'b1; a_data = 4'd5;
    for (int i = 0; i < 8; i++) begin
      a_addr = 3'(i);
      #1;
      checks++;
      if (a_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i, a_ready); end
      tick();
    end
    a_valid = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dig[i] !== 4'd5) begin failures++; $display("FAIL b2b_bcd%0d got=%0d exp=5", i + 1, dig[i]); end
    end
    // cycle N: clear strobe together with a pending B write
    clr = 1'b1;
    b_valid = 1'b1; b_addr = 3'd3; b_data = 4'd4;
    checks++;
    if (b_ready !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL clr_n got=b_ready %b busy %b exp=0 0", b_ready, busy);
    end
    tick();
    clr = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || b_ready !== 1'b0) begin
        failures++; $display("FAIL clr_busy_n%0d got=busy %b b_ready %b exp=1 0", j, busy, b_ready);
      end
      for (int i = 0; i < 8; i++) begin
        exp_v = (i <= j - 2) ? 4'd0 : 4'd5;
        checks++;
        if (dig[i] !== exp_v) begin
          failures++; $display("FAIL clr_bcd%0d_n%0d got=%0d exp=%0d", i + 1, j, dig[i], exp_v);
        end
      end
      tick();
    end
    #1;
    checks++;
    if (busy !== 1'b0 || b_ready !== 1'b1) begin
      failures++; $display("FAIL clr_end got=busy %b b_ready %b exp=0 1", busy, b_ready);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dig[i] !== 4'd0) begin failures++; $display("FAIL clr_zero_bcd%0d got=%0d exp=0", i + 1, dig[i]); end
    end
    tick();
    b_valid = 1'b0;
    #1;
    checks++;
    if (bcd4 !== 4'd4) begin failures++; $display("FAIL clr_post_write got=%0d exp=4", bcd4); end
  endtask

  task automatic test_hold_clr();
    do_reset();
    hold = 1'b1; clr = 1'b1;
    a_valid = 1'b1; a_addr = 3'd5; a_data = 4'd6;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b exp=0", a_ready); end
    tick();
    tick();
    #1;
    checks++;
    if (busy !== 1'b0 || bcd6 !== 4'd0) begin
      failures++; $display("FAIL hold_frozen got=busy %b bcd6 %0d exp=0 0", busy, bcd6);
    end
    hold = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin failures++; $display("FAIL hold_clr_ready got=%b exp=0", a_ready); end
    tick();
    clr = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || a_ready !== 1'b0) begin
      failures++; $display("FAIL hold_clear_start got=busy %b a_ready %b exp=1 0", busy, a_ready);
    end
    for (int j = 0; j < 8; j++) tick();
    #1;
    checks++;
    if (busy !== 1'b0 || a_ready !== 1'b1) begin
      failures++; $display("FAIL hold_clear_end got=busy %b a_ready %b exp=0 1", busy, a_ready);
    end
    tick();
    a_valid = 1'b0;
    #1;
    checks++;
    if (bcd6 !== 4'd6) begin failures++; $display("FAIL hold_write got=%0d exp=6", bcd6); end
  endtask

  task automatic test_clr_held();
    do_reset();
    clr = 1'b1;
    a_valid = 1'b1; a_addr = 3'd1; a_data = 4'd8;
    tick();
    for (int j = 0; j < 8; j++) tick();
    #1;
    checks++;
    if (busy !== 1'b0 || a_ready !== 1'b0) begin
      failures++; $display("FAIL held_gap got=busy %b a_ready %b exp=0 0", busy, a_ready);
    end
    tick();
    clr = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || bcd2 !== 4'd0) begin
      failures++; $display("FAIL held_restart got=busy %b bcd2 %0d exp=1 0", busy, bcd2);
    end
    a_valid = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    a_valid = 1'b1; a_addr = 3'd7; a_data = 4'd8;
    tick();
    a_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    a_valid = 1'b1; a_addr = 3'd4; a_data = 4'd9;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", a_ready); end
    tick();
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dig[i] !== 4'd0) begin failures++; $display("FAIL midrst_bcd%0d got=%0d exp=0", i + 1, dig[i]); end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin failures++; $display("FAIL midrst_release got=%b exp=1", a_ready); end
    tick();
    a_valid = 1'b0;
    #1;
    checks++;
    if (bcd5 !== 4'd9 || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_write got=bcd5 %0d busy %b exp=9 0", bcd5, busy);
    end
  endtask

  // Mutual exclusion of grants is watched over the whole run
  always @(negedge clk) begin
    if (rst === 1'b1 && a_ready === 1'b1 && b_ready === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL dual_grant got=11 exp=at most one");
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_single_write();
    test_contention();
    test_back_to_back_and_clear();
    test_hold_clr();
    test_clr_held();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
